// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register. It handles flush, stall and enable with
// fixed priority, and it generates the stage forwarding value and a stall watchdog counter.
module pipe_stage_reg #(
   parameter int                DATA_W     = 32,
   parameter int                NUM_OPS    = 2,
   parameter int                EXC_W      = 5,
   parameter bit                STALL_MODE = 1'b0,
   parameter int                CNT_W      = 4,
   parameter logic [DATA_W-1:0] PC_DEFAULT = 32'h0000_3000,
   parameter logic [DATA_W-1:0] PC_KERNEL  = 32'h0000_4180
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [DATA_W-1:0]         in_pc,
   input  logic [DATA_W-1:0]         in_instr,
   input  logic [NUM_OPS*DATA_W-1:0] in_ops,
   input  logic [DATA_W-1:0]         in_imm,
   input  logic [EXC_W-1:0]          in_exc,
   input  logic                      in_bd,
   input  logic [1:0]                in_fwd_sel,
   output logic [DATA_W-1:0]         out_pc,
   output logic [DATA_W-1:0]         out_instr,
   output logic [DATA_W-1:0]         out_imm,
   output logic [NUM_OPS*DATA_W-1:0] out_ops,
   output logic [EXC_W-1:0]          out_exc,
   output logic                      out_bd,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_fwd_val,
   output logic                      out_fwd_ok,
   output logic [CNT_W-1:0]          stall_cnt,
   output logic                      stall_sat
);

   localparam int OPS_W = NUM_OPS * DATA_W;

   logic [DATA_W-1:0] pc_q, pc_d, instr_q, instr_d, imm_q, imm_d;
   logic [OPS_W-1:0]  ops_q, ops_d;
   logic [EXC_W-1:0]  exc_q, exc_d;
   logic              bd_q, bd_d, valid_q, valid_d;
   logic [1:0]        fwd_sel_q, fwd_sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   always_comb begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      imm_d     = imm_q;
      ops_d     = ops_q;
      exc_d     = exc_q;
      bd_d      = bd_q;
      valid_d   = valid_q;
      fwd_sel_d = fwd_sel_q;
      if (flush) begin
         pc_d      = PC_KERNEL;
         instr_d   = '0;
         imm_d     = '0;
         ops_d     = '0;
         exc_d     = '0;
         bd_d      = 1'b0;
         valid_d   = 1'b0;
         fwd_sel_d = 2'd0;
      end else if (stall) begin
         // The bubble keeps the PC and BD so that an exception taken here still reports the correct EPC.
         if (!STALL_MODE) begin
            pc_d      = in_pc;
            bd_d      = in_bd;
            instr_d   = '0;
            imm_d     = '0;
            ops_d     = '0;
            exc_d     = '0;
            valid_d   = 1'b0;
            fwd_sel_d = 2'd0;
         end
      end else if (en) begin
         pc_d      = in_pc;
         instr_d   = (in_exc != '0) ? '0 : in_instr;
         imm_d     = in_imm;
         ops_d     = in_ops;
         exc_d     = in_exc;
         bd_d      = in_bd;
         valid_d   = 1'b1;
         fwd_sel_d = (in_exc != '0) ? 2'd0 : in_fwd_sel;
      end
   end

   always_comb begin
      cnt_d = '0;
      if (stall && !flush)
         cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= PC_DEFAULT;
         instr_q   <= '0;
         imm_q     <= '0;
         ops_q     <= '0;
         exc_q     <= '0;
         bd_q      <= 1'b0;
         valid_q   <= 1'b0;
         fwd_sel_q <= 2'd0;
         cnt_q     <= '0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         imm_q     <= imm_d;
         ops_q     <= ops_d;
         exc_q     <= exc_d;
         bd_q      <= bd_d;
         valid_q   <= valid_d;
         fwd_sel_q <= fwd_sel_d;
         cnt_q     <= cnt_d;
      end
   end

   // This stage produces only the PC+8 link value. ALU and DM results are forwarded by later stages.
   assign out_fwd_ok  = valid_q && (fwd_sel_q == 2'd1);
   assign out_fwd_val = out_fwd_ok ? pc_q + DATA_W'(8) : '0;

   assign out_pc    = pc_q;
   assign out_instr = instr_q;
   assign out_imm   = imm_q;
   assign out_ops   = ops_q;
   assign out_exc   = exc_q;
   assign out_bd    = bd_q;
   assign out_valid = valid_q;
   assign stall_cnt = cnt_q;
   assign stall_sat = &cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. It drives a bubble-mode and a hold-mode instance
// side by side from the same inputs.
module tb_pipe_stage_reg;

   logic        clk = 1'b0, reset = 1'b0, en = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0] in_pc = '0, in_instr = '0, in_imm = '0;
   logic [63:0] in_ops = '0;
   logic [4:0]  in_exc = '0;
   logic        in_bd = 1'b0;
   logic [1:0]  in_fwd_sel = '0;

   logic [31:0] pc0, instr0, imm0, fv0, pc1, instr1, imm1, fv1;
   logic [63:0] ops0, ops1;
   logic [4:0]  exc0, exc1;
   logic        bd0, val0, ok0, sat0, bd1, val1, ok1, sat1;
   logic [3:0]  cnt0, cnt1;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.STALL_MODE(1'b0)) u0 (
      .clk(clk), .reset(reset), .en(en), .stall(stall), .flush(flush),
      .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops), .in_imm(in_imm),
      .in_exc(in_exc), .in_bd(in_bd), .in_fwd_sel(in_fwd_sel),
      .out_pc(pc0), .out_instr(instr0), .out_imm(imm0), .out_ops(ops0),
      .out_exc(exc0), .out_bd(bd0), .out_valid(val0), .out_fwd_val(fv0),
      .out_fwd_ok(ok0), .stall_cnt(cnt0), .stall_sat(sat0));

   pipe_stage_reg #(.STALL_MODE(1'b1)) u1 (
      .clk(clk), .reset(reset), .en(en), .stall(stall), .flush(flush),
      .in_pc(in_pc), .in_instr(in_instr), .in_ops(in_ops), .in_imm(in_imm),
      .in_exc(in_exc), .in_bd(in_bd), .in_fwd_sel(in_fwd_sel),
      .out_pc(pc1), .out_instr(instr1), .out_imm(imm1), .out_ops(ops1),
      .out_exc(exc1), .out_bd(bd1), .out_valid(val1), .out_fwd_val(fv1),
      .out_fwd_ok(ok1), .stall_cnt(cnt1), .stall_sat(sat1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Assert reset between edges; its effect must be visible before any clock edge
      #3 reset = 1'b1;
      #1;
      chk("rst_pc0", 64'(pc0), 64'h3000);
      chk("rst_pc1", 64'(pc1), 64'h3000);
      chk("rst_instr", 64'(instr0), 0);
      chk("rst_ops", ops0, 0);
      chk("rst_imm", 64'(imm0), 0);
      chk("rst_exc", 64'(exc0), 0);
      chk("rst_bd", 64'(bd0), 0);
      chk("rst_valid", 64'(val0), 0);
      chk("rst_fwd", {31'd0, ok0, fv0}, 0);
      chk("rst_cnt", {cnt0, sat0}, 0);
      step();
      reset = 1'b0;

      // Plain capture with PC+8 forwarding
      en = 1'b1; in_pc = 32'h3004; in_instr = 32'h0123_4567; in_ops = 64'hBBBB_0002_AAAA_0001;
      in_imm = 32'h10; in_exc = 5'd0; in_bd = 1'b0; in_fwd_sel = 2'd1;
      step();
      chk("cap_pc", 64'(pc0), 64'h3004);
      chk("cap_instr", 64'(instr0), 64'h0123_4567);
      chk("cap_ops", ops0, 64'hBBBB_0002_AAAA_0001);
      chk("cap_imm", 64'(imm0), 64'h10);
      chk("cap_valid", 64'(val0), 1);
      chk("cap_fwd_val", 64'(fv0), 64'h300C);
      chk("cap_fwd_ok", 64'(ok0), 1);

      // When en is low, every field holds
      en = 1'b0; in_pc = 32'h5555; in_instr = 32'hDEAD_BEEF;
      step();
      chk("hold_pc", 64'(pc0), 64'h3004);
      chk("hold_instr", 64'(instr0), 64'h0123_4567);

      // Exception capture: the instruction becomes a nop and forwarding is suppressed
      en = 1'b1; in_pc = 32'h3008; in_instr = 32'h8C01_0000; in_exc = 5'd10;
      in_ops = 64'h0000_0003_0000_0004; in_imm = 32'h20; in_fwd_sel = 2'd1;
      step();
      chk("exc_instr", 64'(instr0), 0);
      chk("exc_code", 64'(exc0), 10);
      chk("exc_pc", 64'(pc0), 64'h3008);
      chk("exc_ops", ops0, 64'h0000_0003_0000_0004);
      chk("exc_valid", 64'(val0), 1);
      chk("exc_fwd", {31'd0, ok0, fv0}, 0);

      // Baseline for the hold-mode stall check
      in_pc = 32'h300C; in_instr = 32'h1111_1111; in_exc = 5'd0; in_ops = 64'h5555_5555_5555_5555;
      in_imm = 32'h30; in_bd = 1'b0; in_fwd_sel = 2'd1;
      step();
      chk("base_pc1", 64'(pc1), 64'h300C);

      // Stall together with en: stall takes priority
      stall = 1'b1; in_pc = 32'h3010; in_bd = 1'b1; in_instr = 32'h2222_2222;
      in_ops = 64'h6666_6666_6666_6666; in_imm = 32'h40; in_exc = 5'd3;
      step();
      chk("bub_pc", 64'(pc0), 64'h3010);
      chk("bub_bd", 64'(bd0), 1);
      chk("bub_instr", 64'(instr0), 0);
      chk("bub_ops", ops0, 0);
      chk("bub_imm_exc", {imm0, 27'd0, exc0}, 0);
      chk("bub_valid", 64'(val0), 0);
      chk("bub_fwd", {31'd0, ok0, fv0}, 0);
      chk("bub_cnt", 64'(cnt0), 1);
      chk("hld_pc", 64'(pc1), 64'h300C);
      chk("hld_instr", 64'(instr1), 64'h1111_1111);
      chk("hld_ops", ops1, 64'h5555_5555_5555_5555);
      chk("hld_imm_exc_bd", {imm1, 26'd0, exc1, bd1}, {32'h30, 32'd0});
      chk("hld_valid", 64'(val1), 1);
      chk("hld_fwd", {31'd0, ok1, fv1}, {32'd1, 32'h3014});
      chk("hld_cnt", {cnt1, sat1}, {4'd1, 1'b0});

      // Hold stall for 20 cycles: the counter saturates at 15 and stays there
      for (int i = 2; i <= 20; i++) begin
         step();
         if (i == 14) chk("cnt14", {cnt0, sat0}, {4'd14, 1'b0});
         if (i == 15) chk("cnt15", {cnt0, sat0}, {4'd15, 1'b1});
         if (i == 20) chk("cnt20", {cnt0, sat0}, {4'd15, 1'b1});
      end

      stall = 1'b0; en = 1'b0;
      step();
      chk("cnt_clr", {cnt0, sat0}, 0);
      chk("hld_after_pc1", 64'(pc1), 64'h300C);

      // Flush, stall and en on the same edge: flush takes priority and clears the counter
      stall = 1'b1;
      step();
      chk("pre_flush_cnt", 64'(cnt0), 1);
      flush = 1'b1; en = 1'b1;
      step();
      chk("fl_pc0", 64'(pc0), 64'h4180);
      chk("fl_pc1", 64'(pc1), 64'h4180);
      chk("fl_valid", {val0, val1}, 0);
      chk("fl_instr", {instr0, instr1}, 0);
      chk("fl_cnt", {cnt0, cnt1}, 0);
      chk("fl_misc", {ops0, 5'd0, exc0, bd0}, 0);

      // PC+8 wraps modulo 2^32
      flush = 1'b0; stall = 1'b0; en = 1'b1; in_pc = 32'hFFFF_FFFC; in_exc = 5'd0; in_fwd_sel = 2'd1;
      step();
      chk("wrap_fwd", {31'd0, ok0, fv0}, {32'd1, 32'h4});

      // Assert reset in the middle of a stall: the counter restarts from zero
      en = 1'b0; stall = 1'b1;
      step(); step(); step();
      chk("mid_cnt", 64'(cnt0), 3);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_pc", {pc0, pc1}, {32'h3000, 32'h3000});
      chk("mid_rst_cnt", {cnt0, cnt1}, 0);
      chk("mid_rst_valid", {val0, ok0}, 0);
      #1 reset = 1'b0;
      step();
      chk("post_rst_cnt", 64'(cnt0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
